// File: rtl/pgm_rd_if.sv
// Read port between pgm_rd and PGM_RAM.
// Read data is valid exactly one cycle after rd_en.
interface pgm_rd_if;
    logic         rd2ram_rd_en;
    logic [6:0]   rd2ram_addr;
    logic [143:0] ram2rd_rdata;

    modport master (
        output rd2ram_rd_en,
        output rd2ram_addr,
        input  ram2rd_rdata
    );

    modport slave (
        input  rd2ram_rd_en,
        input  rd2ram_addr,
        output ram2rd_rdata
    );
endinterface

// File: rtl/pgm_rd.sv
// Read side of the packet generator: forwards bypass packets from pgm_wr and
// replays the PGM_RAM template packet with a programmable gap between copies.
module pgm_rd #(
    parameter string       PLATFORM   = "Xilinx",
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned RAM_DEPTH  = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1023:0] in_rd_phv,
    input  logic          in_rd_phv_wr,
    input  logic [133:0]  in_rd_data,
    input  logic          in_rd_data_wr,
    input  logic          in_rd_valid,
    input  logic          in_rd_valid_wr,
    input  logic          pgm_bypass_flag,
    input  logic          pgm_sent_start_flag,
    input  logic          pgm_sent_finish_flag,
    pgm_rd_if.master      ram,
    output logic [1023:0] out_rd_phv,
    output logic          out_rd_phv_wr,
    output logic [133:0]  out_rd_data,
    output logic          out_rd_data_wr,
    output logic          out_rd_valid,
    output logic          out_rd_valid_wr,
    input  logic          in_rd_alf,
    output logic          out_rd_alf,
    output logic [31:0]   gen_pkt_cnt,
    output logic          gen_err
);

    typedef enum logic [1:0] {StIdle, StBypass, StGenRd, StGenGap} state_e;

    localparam logic [6:0] LastAddr    = 7'(RAM_DEPTH - 1);
    localparam logic [7:0] GapLoad     = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 1) : 8'd1;
    localparam bit         FastRestart = (GAP_CYCLES <= 1);

    state_e         state_q, state_d;
    logic           start_d_q, fin_d_q;
    logic           stop_req_q, stop_req_d;
    logic           start_pend_q, start_pend_d;
    logic           rd_en_q, rd_en_d;
    logic [6:0]     addr_q, addr_d;
    logic           rd_vld_q, rd_vld_d;
    logic [6:0]     rd_addr_q, rd_addr_d;
    logic [7:0]     gap_cnt_q, gap_cnt_d;
    logic [1023:0]  out_phv_q, out_phv_d;
    logic           out_phv_wr_q, out_phv_wr_d;
    logic [133:0]   out_data_q, out_data_d;
    logic           out_data_wr_q, out_data_wr_d;
    logic           out_valid_q, out_valid_d;
    logic           out_valid_wr_q, out_valid_wr_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           err_q, err_d;

    logic           start_rise, fin_rise, stop_now;
    logic           in_head, in_tail, r_head, r_tail;
    logic [133:0]   rword;
    logic           unused_bits;

    assign start_rise = pgm_sent_start_flag & ~start_d_q;
    assign fin_rise   = pgm_sent_finish_flag & ~fin_d_q;
    assign stop_now   = stop_req_q | fin_rise;
    assign in_head    = (in_rd_data[133:132] == 2'b01);
    assign in_tail    = (in_rd_data[133:132] == 2'b10);
    assign rword      = ram.ram2rd_rdata[133:0];
    assign r_head     = (rword[133:132] == 2'b01);
    assign r_tail     = (rword[133:132] == 2'b10);

    assign unused_bits = ^{ram.ram2rd_rdata[143:134], pgm_bypass_flag, (PLATFORM == "Xilinx")};

    always_comb begin
        state_d        = state_q;
        start_pend_d   = start_pend_q;
        rd_en_d        = rd_en_q;
        addr_d         = addr_q;
        rd_vld_d       = 1'b0;
        rd_addr_d      = rd_addr_q;
        gap_cnt_d      = gap_cnt_q;
        out_phv_d      = out_phv_q;
        out_phv_wr_d   = 1'b0;
        out_data_d     = out_data_q;
        out_data_wr_d  = 1'b0;
        out_valid_d    = out_valid_q;
        out_valid_wr_d = 1'b0;
        cnt_d          = cnt_q;
        err_d          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_rd_data_wr && in_head) begin
                    out_phv_d      = in_rd_phv;
                    out_phv_wr_d   = in_rd_phv_wr;
                    out_data_d     = in_rd_data;
                    out_data_wr_d  = 1'b1;
                    out_valid_d    = in_rd_valid;
                    out_valid_wr_d = in_rd_valid_wr;
                    state_d        = StBypass;
                    if (start_rise) start_pend_d = 1'b1;
                end else if (start_rise || start_pend_q) begin
                    start_pend_d = 1'b0;
                    rd_en_d      = 1'b1;
                    addr_d       = '0;
                    state_d      = StGenRd;
                end
            end
            StBypass: begin
                out_phv_d      = in_rd_phv;
                out_phv_wr_d   = in_rd_phv_wr;
                out_data_d     = in_rd_data;
                out_data_wr_d  = in_rd_data_wr;
                out_valid_d    = in_rd_valid;
                out_valid_wr_d = in_rd_valid_wr;
                if (start_rise) start_pend_d = 1'b1;
                if (in_rd_data_wr && in_tail) state_d = StIdle;
            end
            StGenRd: begin
                rd_vld_d = rd_en_q;
                if (rd_en_q) begin
                    rd_addr_d = addr_q;
                    if (addr_q == LastAddr) rd_en_d = 1'b0;
                    else                    addr_d  = addr_q + 7'd1;
                end
                if (rd_vld_q) begin
                    if ((rd_addr_q == '0 && !r_head) || (rd_addr_q == LastAddr && !r_tail)) begin
                        err_d    = 1'b1;
                        rd_en_d  = 1'b0;
                        rd_vld_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        out_data_d    = rword;
                        out_data_wr_d = 1'b1;
                        if (rd_addr_q == '0) begin
                            out_phv_d    = '0;
                            out_phv_wr_d = 1'b1;
                        end
                        if (r_tail) begin
                            // The word issued alongside the tail is over-read and dropped.
                            out_valid_d    = 1'b1;
                            out_valid_wr_d = 1'b1;
                            cnt_d          = cnt_q + 32'd1;
                            rd_vld_d       = 1'b0;
                            rd_en_d        = 1'b0;
                            if (stop_now) begin
                                state_d = StIdle;
                            end else if (FastRestart && !in_rd_alf) begin
                                rd_en_d = 1'b1;
                                addr_d  = '0;
                            end else begin
                                gap_cnt_d = GapLoad;
                                state_d   = StGenGap;
                            end
                        end
                    end
                end
            end
            StGenGap: begin
                if (gap_cnt_q > 8'd1) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (stop_now) begin
                    state_d = StIdle;
                end else if (!in_rd_alf) begin
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                    state_d = StGenRd;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle)                   stop_req_d = 1'b0;
        else if (fin_rise && state_q != StIdle)  stop_req_d = 1'b1;
        else                                     stop_req_d = stop_req_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            start_d_q      <= 1'b0;
            fin_d_q        <= 1'b0;
            stop_req_q     <= 1'b0;
            start_pend_q   <= 1'b0;
            rd_en_q        <= 1'b0;
            addr_q         <= '0;
            rd_vld_q       <= 1'b0;
            rd_addr_q      <= '0;
            gap_cnt_q      <= '0;
            out_phv_q      <= '0;
            out_phv_wr_q   <= 1'b0;
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_d_q      <= pgm_sent_start_flag;
            fin_d_q        <= pgm_sent_finish_flag;
            stop_req_q     <= stop_req_d;
            start_pend_q   <= start_pend_d;
            rd_en_q        <= rd_en_d;
            addr_q         <= addr_d;
            rd_vld_q       <= rd_vld_d;
            rd_addr_q      <= rd_addr_d;
            gap_cnt_q      <= gap_cnt_d;
            out_phv_q      <= out_phv_d;
            out_phv_wr_q   <= out_phv_wr_d;
            out_data_q     <= out_data_d;
            out_data_wr_q  <= out_data_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
        end
    end

    assign ram.rd2ram_rd_en = rd_en_q;
    assign ram.rd2ram_addr  = addr_q;
    assign out_rd_phv       = out_phv_q;
    assign out_rd_phv_wr    = out_phv_wr_q;
    assign out_rd_data      = out_data_q;
    assign out_rd_data_wr   = out_data_wr_q;
    assign out_rd_valid     = out_valid_q;
    assign out_rd_valid_wr  = out_valid_wr_q;
    assign out_rd_alf       = in_rd_alf;
    assign gen_pkt_cnt      = cnt_q;
    assign gen_err          = err_q;

endmodule

// File: tb/tb_pgm_rd.sv
// Directed bench for pgm_rd: bypass, template replay with gap, backpressure,
// finish, reset mid-copy and malformed templates, against a behavioural RAM.
module tb_pgm_rd;

    logic          clk, rst;
    logic [1023:0] in_rd_phv, out_rd_phv;
    logic          in_rd_phv_wr, out_rd_phv_wr;
    logic [133:0]  in_rd_data, out_rd_data;
    logic          in_rd_data_wr, out_rd_data_wr;
    logic          in_rd_valid, out_rd_valid;
    logic          in_rd_valid_wr, out_rd_valid_wr;
    logic          pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
    logic          in_rd_alf, out_rd_alf;
    logic [31:0]   gen_pkt_cnt;
    logic          gen_err;

    pgm_rd_if ram_if ();

    pgm_rd dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_rd_phv            (in_rd_phv),
        .in_rd_phv_wr         (in_rd_phv_wr),
        .in_rd_data           (in_rd_data),
        .in_rd_data_wr        (in_rd_data_wr),
        .in_rd_valid          (in_rd_valid),
        .in_rd_valid_wr       (in_rd_valid_wr),
        .pgm_bypass_flag      (pgm_bypass_flag),
        .pgm_sent_start_flag  (pgm_sent_start_flag),
        .pgm_sent_finish_flag (pgm_sent_finish_flag),
        .ram                  (ram_if),
        .out_rd_phv           (out_rd_phv),
        .out_rd_phv_wr        (out_rd_phv_wr),
        .out_rd_data          (out_rd_data),
        .out_rd_data_wr       (out_rd_data_wr),
        .out_rd_valid         (out_rd_valid),
        .out_rd_valid_wr      (out_rd_valid_wr),
        .in_rd_alf            (in_rd_alf),
        .out_rd_alf           (out_rd_alf),
        .gen_pkt_cnt          (gen_pkt_cnt),
        .gen_err              (gen_err)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [133:0] mem [128];
    int           heads [5] = '{2, 10, 18, 30, 38};
    logic [1023:0] phv_pat;

    logic         exp_dwr, exp_vwr, exp_pwr, exp_rd;
    int           exp_addr, exp_cnt;
    logic [133:0] exp_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upper rdata bits are set to show they are ignored.
    always @(posedge clk) begin
        if (ram_if.rd2ram_rd_en)
            ram_if.ram2rd_rdata <= {10'h3ff, mem[ram_if.rd2ram_addr]};
    end

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [133:0] w(input logic [1:0] t, input int v);
        w = {t, 132'(v)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bypass_pkt();
        in_rd_phv      = phv_pat;
        in_rd_phv_wr   = 1'b1;
        in_rd_data     = w(2'b01, 'h111);
        in_rd_data_wr  = 1'b1;
        step();
        check_eq("byp_head_wr", out_rd_data_wr, 1'b1);
        check_eq("byp_head", out_rd_data, w(2'b01, 'h111));
        check_eq("byp_phv_wr", out_rd_phv_wr, 1'b1);
        check_eq("byp_phv_lo", out_rd_phv[159:0], phv_pat[159:0]);
        check_eq("byp_phv_hi", out_rd_phv[1023:864], phv_pat[1023:864]);
        check_eq("byp_head_vwr", out_rd_valid_wr, 1'b0);
        in_rd_phv_wr   = 1'b0;
        in_rd_data     = w(2'b11, 'h222);
        step();
        check_eq("byp_mid", out_rd_data, w(2'b11, 'h222));
        check_eq("byp_mid_pwr", out_rd_phv_wr, 1'b0);
        in_rd_data     = w(2'b10, 'h333);
        in_rd_valid    = 1'b1;
        in_rd_valid_wr = 1'b1;
        step();
        check_eq("byp_tail", out_rd_data, w(2'b10, 'h333));
        check_eq("byp_tail_wr", out_rd_data_wr, 1'b1);
        check_eq("byp_tail_vwr", out_rd_valid_wr, 1'b1);
        check_eq("byp_tail_v", out_rd_valid, 1'b1);
        in_rd_data_wr  = 1'b0;
        in_rd_valid    = 1'b0;
        in_rd_valid_wr = 1'b0;
        step();
        check_eq("byp_after_wr", out_rd_data_wr, 1'b0);
        check_eq("byp_cnt", gen_pkt_cnt, 32'd0);
    endtask

    initial begin
        phv_pat              = {128{8'hA5}};
        rst                  = 1'b1;
        in_rd_phv            = '0;
        in_rd_phv_wr         = 1'b0;
        in_rd_data           = '0;
        in_rd_data_wr        = 1'b0;
        in_rd_valid          = 1'b0;
        in_rd_valid_wr       = 1'b0;
        pgm_bypass_flag      = 1'b0;
        pgm_sent_start_flag  = 1'b0;
        pgm_sent_finish_flag = 1'b0;
        in_rd_alf            = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[0] = w(2'b01, 'h1000);
        mem[1] = w(2'b11, 'h1001);
        mem[2] = w(2'b11, 'h1002);
        mem[3] = w(2'b10, 'h1003);
        mem[4] = w(2'b01, 'h1004);

        step();
        step();
        check_eq("rst_dwr", out_rd_data_wr, 1'b0);
        check_eq("rst_pwr", out_rd_phv_wr, 1'b0);
        check_eq("rst_vwr", out_rd_valid_wr, 1'b0);
        check_eq("rst_rd_en", ram_if.rd2ram_rd_en, 1'b0);
        check_eq("rst_cnt", gen_pkt_cnt, 32'd0);
        check_eq("rst_err", gen_err, 1'b0);
        rst = 1'b0;

        in_rd_alf = 1'b1;
        #1;
        check_eq("alf_hi", out_rd_alf, 1'b1);
        in_rd_alf = 1'b0;
        #1;
        check_eq("alf_lo", out_rd_alf, 1'b0);

        bypass_pkt();

        // A non-head word in IDLE is dropped.
        in_rd_data    = w(2'b11, 'h444);
        in_rd_data_wr = 1'b1;
        step();
        check_eq("idle_drop", out_rd_data_wr, 1'b0);
        in_rd_data_wr = 1'b0;
        step();

        // Replay, backpressure during copy 3, finish during copy 5.
        pgm_sent_start_flag = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            step();
            exp_dwr = 1'b0; exp_vwr = 1'b0; exp_pwr = 1'b0; exp_rd = 1'b0;
            exp_addr = 0; exp_cnt = 0; exp_word = '0;
            for (int i = 0; i < 5; i++) begin
                if (k >= heads[i] && k <= heads[i] + 3) begin
                    exp_dwr  = 1'b1;
                    exp_word = mem[k - heads[i]];
                end
                if (k == heads[i])     exp_pwr = 1'b1;
                if (k == heads[i] + 3) exp_vwr = 1'b1;
                if (k >= heads[i] - 2 && k <= heads[i] + 2) begin
                    exp_rd   = 1'b1;
                    exp_addr = k - heads[i] + 2;
                end
                if (k >= heads[i] + 3) exp_cnt++;
            end
            check_eq($sformatf("rep_dwr_k%0d", k), out_rd_data_wr, exp_dwr);
            check_eq($sformatf("rep_rd_en_k%0d", k), ram_if.rd2ram_rd_en, exp_rd);
            check_eq($sformatf("rep_pwr_k%0d", k), out_rd_phv_wr, exp_pwr);
            check_eq($sformatf("rep_vwr_k%0d", k), out_rd_valid_wr, exp_vwr);
            check_eq($sformatf("rep_cnt_k%0d", k), gen_pkt_cnt, 32'(exp_cnt));
            if (exp_dwr) check_eq($sformatf("rep_data_k%0d", k), out_rd_data, exp_word);
            if (exp_rd)  check_eq($sformatf("rep_addr_k%0d", k), ram_if.rd2ram_addr, 7'(exp_addr));
            if (exp_pwr) check_eq($sformatf("rep_phv_k%0d", k), out_rd_phv[159:0], 160'd0);
            if (exp_vwr) check_eq($sformatf("rep_valid_k%0d", k), out_rd_valid, 1'b1);
            in_rd_alf            = (k >= 19 && k <= 26);
            pgm_sent_finish_flag = (k >= 38);
            in_rd_data           = w(2'b01, 'h555);
            in_rd_data_wr        = (k == 3 || k == 7);
        end
        in_rd_data_wr = 1'b0;

        pgm_sent_start_flag  = 1'b0;
        pgm_sent_finish_flag = 1'b0;
        step();
        step();
        check_eq("fin_idle_rd", ram_if.rd2ram_rd_en, 1'b0);
        pgm_sent_start_flag = 1'b1;
        step();
        check_eq("restart_rd", ram_if.rd2ram_rd_en, 1'b1);
        check_eq("restart_addr", ram_if.rd2ram_addr, 7'd0);
        step();
        step();
        check_eq("restart_head_wr", out_rd_data_wr, 1'b1);
        check_eq("restart_head", out_rd_data, mem[0]);
        check_eq("restart_cnt", gen_pkt_cnt, 32'd5);

        // Synchronous reset mid-copy.
        rst                 = 1'b1;
        pgm_sent_start_flag = 1'b0;
        step();
        check_eq("mrst_dwr", out_rd_data_wr, 1'b0);
        check_eq("mrst_data", out_rd_data, 134'd0);
        check_eq("mrst_rd_en", ram_if.rd2ram_rd_en, 1'b0);
        check_eq("mrst_addr", ram_if.rd2ram_addr, 7'd0);
        check_eq("mrst_cnt", gen_pkt_cnt, 32'd0);
        rst = 1'b0;
        step();
        check_eq("mrst_no_tail", out_rd_data_wr, 1'b0);
        check_eq("mrst_no_vwr", out_rd_valid_wr, 1'b0);
        bypass_pkt();

        // Malformed: addr 0 is not a head.
        mem[0]              = w(2'b11, 'h2000);
        pgm_sent_start_flag = 1'b1;
        step();
        step();
        step();
        check_eq("bad_head_err", gen_err, 1'b1);
        check_eq("bad_head_dwr", out_rd_data_wr, 1'b0);
        check_eq("bad_head_vwr", out_rd_valid_wr, 1'b0);
        step();
        check_eq("bad_head_pulse", gen_err, 1'b0);
        check_eq("bad_head_rd", ram_if.rd2ram_rd_en, 1'b0);
        check_eq("bad_head_cnt", gen_pkt_cnt, 32'd0);
        pgm_sent_start_flag = 1'b0;
        step();

        // Malformed: no tail anywhere in 0..127.
        mem[0] = w(2'b01, 'h3000);
        for (int i = 1; i < 128; i++) mem[i] = w(2'b11, 'h3000 + i);
        pgm_sent_start_flag = 1'b1;
        for (int k = 0; k <= 131; k++) begin
            step();
            check_eq($sformatf("nt_err_k%0d", k), gen_err, (k == 129));
            check_eq($sformatf("nt_rd_k%0d", k), ram_if.rd2ram_rd_en, (k <= 127));
            check_eq($sformatf("nt_dwr_k%0d", k), out_rd_data_wr, (k >= 2 && k <= 128));
            check_eq($sformatf("nt_vwr_k%0d", k), out_rd_valid_wr, 1'b0);
            if (k == 127) check_eq("nt_last_addr", ram_if.rd2ram_addr, 7'd127);
        end
        check_eq("nt_cnt", gen_pkt_cnt, 32'd0);
        pgm_sent_start_flag = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pgm_rd.md
Name: pgm_rd

Overview:
- Read side of the packet generator. It forwards bypass traffic arriving from pgm_wr.
- On the start flag from pgm_wr, it replays the template packet stored in PGM_RAM: one word per cycle, back-to-back copies separated by a programmable gap.
- Replay stops after the copy in flight when the finish flag rises.
- Sits between pgm_wr and the next pipeline module; its only RAM access is the RAM read port.

Parameters:
- PLATFORM, "Xilinx", target vendor.
- GAP_CYCLES, 4, idle cycles between end of one generated copy and start of the next (range 0..255).
- RAM_DEPTH, 128, PGM_RAM words; address width fixed at 7.

Ports:
- clk  in  1  clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- in_rd_phv  in  1024  PHV from pgm_wr.
- in_rd_phv_wr  in  1  PHV strobe.
- in_rd_data  in  134  packet word from pgm_wr; [133:132] is 01 for head, 11 for middle, 10 for tail.
- in_rd_data_wr  in  1  data strobe.
- in_rd_valid  in  1  packet-valid bit.
- in_rd_valid_wr  in  1  valid strobe.
- pgm_bypass_flag  in  1  pgm_wr is forwarding a bypass packet.
- pgm_sent_start_flag  in  1  template stored; rising edge starts generation.
- pgm_sent_finish_flag  in  1  rising edge requests stop.
- rd2ram_rd_en  out  1  RAM read enable.
- rd2ram_addr  out  7  RAM read address.
- ram2rd_rdata  in  144  RAM read data, valid exactly 1 cycle after rd_en; [133:0] is the packet word.
- out_rd_phv  out  1024  PHV to next module.
- out_rd_phv_wr  out  1  PHV strobe.
- out_rd_data  out  134  packet word to next module.
- out_rd_data_wr  out  1  data strobe.
- out_rd_valid  out  1  packet-valid bit.
- out_rd_valid_wr  out  1  valid strobe.
- in_rd_alf  in  1  downstream almost-full.
- out_rd_alf  out  1  upstream almost-full; combinationally equal to in_rd_alf.
- gen_pkt_cnt  out  32  generated copies completed since reset.
- gen_err  out  1  one-cycle pulse on a malformed template.

Behaviour:
- Reset (rst=1 at a posedge):
  - All registered outputs 0, gen_pkt_cnt 0, state IDLE, stop_req 0, edge-detect registers 0.
  - Reset mid-packet truncates output immediately; no tail is emitted.
- Edge detect: start_rise = start & ~start_d and fin_rise = fin & ~fin_d, with registered delays.
- stop_req:
  - Set on fin_rise in any state other than IDLE.
  - Cleared on entering IDLE.
- States: IDLE, BYPASS, GEN_RD, GEN_GAP.
- IDLE:
  - If in_rd_data_wr is set with head [133:132]=01, forward the word, go to BYPASS.
  - Else, if start_rise, go to GEN_RD with addr=0. Generation does not wait on in_rd_alf.
  - Else all strobes 0.
  - A simultaneous head and start_rise favours the bypass; the start is held pending and taken on return to IDLE.
- BYPASS:
  - Registered passthrough with 1-cycle latency: out_* <= in_* and each *_wr <= its input strobe.
  - Tail word: out_rd_valid=1 and out_rd_valid_wr=1 with it, then return to IDLE.
  - A cycle with in_rd_data_wr=0 gives all strobes 0 and stays in BYPASS.
- GEN_RD:
  - Issue rd_en=1 with addr incrementing every cycle, starting at 0.
  - Each returned word (1 cycle later) is driven on out_rd_data with out_rd_data_wr=1, so output lags issue by 2 cycles.
  - Head word: out_rd_phv_wr=1 with out_rd_phv=0.
  - Returned tail word: out_rd_valid=1, out_rd_valid_wr=1; stop issuing; the one over-read word is discarded; gen_pkt_cnt += 1 (wraps at 2^32).
  - After the tail: go to IDLE if stop_req, else GEN_GAP.
  - Returned word at addr 0 that is not a head, or no tail by addr 127 (address never wraps): gen_err pulse, close with no further strobes, go to IDLE.
- GEN_GAP:
  - Count GAP_CYCLES cycles with all strobes 0.
  - Then, if stop_req, go to IDLE.
  - Else, if in_rd_alf=0, go to GEN_RD with addr=0.
  - Else hold in GEN_GAP until alf drops.
  - GAP_CYCLES=0 means the next head follows the previous tail on the next issue cycle, subject to alf.
- in_rd_alf never pauses a copy mid-packet; it only gates the start of the next copy.
- in_rd_data_wr during GEN_RD or GEN_GAP is dropped silently (pgm_wr does not forward in this phase).

Test Plan:
- Bypass: 3-word packet (01, 11, 10) with PHV=0xA5.. in IDLE -> identical words 1 cycle later; phv_wr only on the head; valid/valid_wr=1 on the tail; gen_pkt_cnt stays 0.
- Replay: RAM holds 4 words (01, 11, 11, 10), start_rise, GAP_CYCLES=4 -> first head on out 2 cycles after start_rise; copies of 4 words each separated by exactly 4 idle cycles; gen_pkt_cnt increments on each tail.
- Backpressure: in_rd_alf=1 asserted mid-copy -> the copy completes all 4 words; next head held until alf=0, then emitted with rd_en 2 cycles earlier.
- Finish: fin_rise during word 2 of a copy -> copy completes through its tail, no further rd_en, state IDLE; a new start_rise restarts at addr 0.
- Malformed: RAM addr 0 holds [133:132]=11, or no tail in 0..127 -> gen_err single-cycle pulse, out_rd_valid_wr=0, state IDLE, gen_pkt_cnt unchanged.
- Reset: rst=1 during a generated copy -> next cycle all outputs 0, rd_en 0, gen_pkt_cnt 0; bypass packet after rst deasserts forwards normally.
